// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types, defaults and width helpers for the 2-way dcache
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_NUM_SETS   = 16;
  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    REFILL      = 2'd2,
    REFILL_DONE = 2'd3
  } state_t;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int num_sets);
    return ADDR_W - idx_w(num_sets) - off_w(line_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sa_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sa_if
// Description : CPU-side and memory-side bus of the 2-way dcache
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_sa_if import dcache_pkg::*; #(
  parameter int MEM_W = DEF_LINE_BYTES * 8
) ();

  logic [WORD_W-1:0] p1_data_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [WORD_W-1:0] p1_data_o;
  logic              p1_stall_o;

  logic [MEM_W-1:0]  mem_data_i;
  logic              mem_ack_i;
  logic [MEM_W-1:0]  mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  // slave is the cache itself; master is the CPU plus memory environment
  modport slave (
    input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

endinterface
`default_nettype wire

// File: rtl/dcache_sa_way.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sa_way
// Description : One cache way - valid/dirty/tag/line arrays, async read
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sa_way import dcache_pkg::*; #(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 23,
  parameter int MEM_W    = 256,
  parameter int WSEL_W   = 3
) (
  input  wire               clk,
  input  wire               rst,
  input  wire  [IDX_W-1:0]  i_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [MEM_W-1:0]  o_line,
  input  wire               i_word_we,
  input  wire  [WSEL_W-1:0] i_word_sel,
  input  wire  [WORD_W-1:0] i_word,
  input  wire               i_line_we,
  input  wire  [TAG_W-1:0]  i_line_tag,
  input  wire  [MEM_W-1:0]  i_line
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [MEM_W-1:0]    r_data [NUM_SETS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset so they can map onto RAM
  always_ff @(posedge clk) begin
    if (i_line_we) begin
      r_tag[i_idx]  <= i_line_tag;
      r_data[i_idx] <= i_line;
    end else if (i_word_we) begin
      r_data[i_idx][{i_word_sel, 5'd0} +: WORD_W] <= i_word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_sa_top.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sa_top
// Description : 2-way set-associative write-back dcache with LRU replacement
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sa_top import dcache_pkg::*; #(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input wire         clk_i,
  input wire         rst_i,
  dcache_sa_if.slave bus
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(LINE_BYTES, NUM_SETS);
  localparam int MEM_W  = LINE_BYTES * 8;
  localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;

  logic              w_req;
  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic [1:0]        w_valid;
  logic [1:0]        w_dirty;
  logic [1:0]        w_way_hit;
  logic [1:0]        w_word_we;
  logic [1:0]        w_line_we;
  logic [TAG_W-1:0]  w_tag  [2];
  logic [MEM_W-1:0]  w_line [2];
  logic              w_hit;
  logic              w_hit_way;
  logic              w_victim;
  logic              w_unused;

  state_t            r_state;
  logic              r_victim;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_SETS-1:0] r_lru;
  logic              r_mem_enable;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [MEM_W-1:0]  r_mem_data;

  assign w_req     = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign w_req_tag = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_req_idx = bus.p1_addr_i[OFF_W +: IDX_W];
  assign w_unused  = &{1'b0, bus.p1_addr_i[1:0]};

  generate
    if (OFF_W > 2) begin : g_wsel_multi
      assign w_wsel = bus.p1_addr_i[2 +: WSEL_W];
    end else begin : g_wsel_single
      assign w_wsel = '0;
    end
  endgenerate

  // Outside IDLE the arrays are addressed by the latched miss index
  assign w_idx = (r_state == IDLE) ? w_req_idx : r_idx;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_way
      assign w_way_hit[g] = w_valid[g] & (w_tag[g] == w_req_tag);
      assign w_word_we[g] = w_hit & bus.p1_MemWrite_i & (w_hit_way == 1'(g)) & ~rst_i;
      assign w_line_we[g] = (r_state == REFILL) & bus.mem_ack_i & (r_victim == 1'(g)) & ~rst_i;

      dcache_sa_way #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .MEM_W    (MEM_W),
        .WSEL_W   (WSEL_W)
      ) u_way (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_idx      (w_idx),
        .o_valid    (w_valid[g]),
        .o_dirty    (w_dirty[g]),
        .o_tag      (w_tag[g]),
        .o_line     (w_line[g]),
        .i_word_we  (w_word_we[g]),
        .i_word_sel (w_wsel),
        .i_word     (bus.p1_data_i),
        .i_line_we  (w_line_we[g]),
        .i_line_tag (r_tag),
        .i_line     (bus.mem_data_i)
      );
    end
  endgenerate

  assign w_hit     = (r_state == IDLE) & w_req & (|w_way_hit);
  assign w_hit_way = ~w_way_hit[0];
  assign w_victim  = ~w_valid[0] ? 1'b0 : (~w_valid[1] ? 1'b1 : r_lru[w_req_idx]);

  assign bus.p1_data_o    = w_hit ? w_line[w_hit_way][{w_wsel, 5'd0} +: WORD_W] : '0;
  assign bus.p1_stall_o   = w_req & ~w_hit;
  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_victim     <= 1'b0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_lru        <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_lru[w_req_idx] <= ~w_hit_way;
          end else if (w_req) begin
            r_victim     <= w_victim;
            r_tag        <= w_req_tag;
            r_idx        <= w_req_idx;
            r_mem_enable <= 1'b1;
            if (w_valid[w_victim] & w_dirty[w_victim]) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {w_tag[w_victim], w_req_idx, {OFF_W{1'b0}}};
              r_mem_data  <= w_line[w_victim];
            end else begin
              r_state     <= REFILL;
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_req_tag, w_req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            r_state     <= REFILL;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {r_tag, r_idx, {OFF_W{1'b0}}};
            r_mem_data  <= '0;
          end
        end
        REFILL: begin
          if (bus.mem_ack_i) begin
            r_state      <= REFILL_DONE;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
          end
        end
        REFILL_DONE: r_state <= IDLE;
        default:     r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_sa_top
// Description : Directed and random bench for dcache_sa_top with a line-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_sa_top;
  import dcache_pkg::*;

  localparam int MEM_W = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_sa_if #(.MEM_W(MEM_W)) bus ();

  dcache_sa_top dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per set two ways plus an LRU flag, and a sparse backing memory
  logic             m_valid [16][2];
  logic             m_dirty [16][2];
  logic [22:0]      m_tag   [16][2];
  logic [MEM_W-1:0] m_line  [16][2];
  logic             m_lru   [16];
  logic [MEM_W-1:0] mem [logic [31:0]];

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkl(input string tag, input logic [MEM_W-1:0] obs, input logic [MEM_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %064h expected %064h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] get_line(input logic [31:0] a);
    logic [MEM_W-1:0] l;
    if (!mem.exists(a)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem[a] = l;
    end
    return mem[a];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endfunction

  // One CPU access, acting as the memory too; dly = cycles enable is held before ack
  task automatic cpu_access(input bit wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] wdata, input int dly, input bit abort);
    int idx, wsel, h, v, waited, rd_cnt;
    logic [22:0] tg;
    logic [31:0] la, wb_addr;
    logic [MEM_W-1:0] wb_line;
    bit exp_wb, wb_done, rf_done, done;
    idx  = int'(addr[8:5]);
    wsel = int'(addr[4:2]);
    tg   = addr[31:9];
    la   = {addr[31:5], 5'b0};
    h = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) h = w;
    v = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
    exp_wb  = (h < 0) && m_valid[idx][v] && m_dirty[idx][v];
    wb_addr = {m_tag[idx][v], addr[8:5], 5'b0};
    wb_line = m_line[idx][v];
    waited = 0; rd_cnt = 0; wb_done = 0; rf_done = 0; done = 0;

    @(negedge clk);
    bus.p1_addr_i     = addr;
    bus.p1_data_i     = wdata;
    bus.p1_MemWrite_i = wr;
    bus.p1_MemRead_i  = !wr || both;
    bus.mem_ack_i     = 1'b0;
    #1;
    check1("stall_on_entry", bus.p1_stall_o, h < 0);
    check1("idle_mem_enable", bus.mem_enable_o, 1'b0);
    if (h >= 0) done = 1;

    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      if (!bus.p1_stall_o) begin
        done = 1;
      end else begin
        check32("miss_data_zero", bus.p1_data_o, 32'h0);
        if (exp_wb && !wb_done) begin
          check1("wb_enable", bus.mem_enable_o, 1'b1);
          check1("wb_write", bus.mem_write_o, 1'b1);
          check32("wb_addr", bus.mem_addr_o, wb_addr);
          checkl("wb_data", bus.mem_data_o, wb_line);
          if (waited == dly) begin
            bus.mem_ack_i = 1'b1;
            mem[wb_addr] = wb_line;
            wb_done = 1;
            waited = 0;
          end else waited++;
        end else if (!rf_done) begin
          check1("rf_enable", bus.mem_enable_o, 1'b1);
          check1("rf_write", bus.mem_write_o, 1'b0);
          check32("rf_addr", bus.mem_addr_o, la);
          if (waited == dly) begin
            if (abort) begin
              rst = 1'b1;
              @(negedge clk);
              rst = 1'b0;
              bus.p1_MemRead_i  = 1'b0;
              bus.p1_MemWrite_i = 1'b0;
              #1;
              check1("abort_enable", bus.mem_enable_o, 1'b0);
              check1("abort_write", bus.mem_write_o, 1'b0);
              check32("abort_addr", bus.mem_addr_o, 32'h0);
              check1("abort_stall", bus.p1_stall_o, 1'b0);
              check32("abort_state", 32'(dut.r_state), 32'(IDLE));
              model_reset();
              return;
            end
            bus.mem_data_i = get_line(la);
            bus.mem_ack_i  = 1'b1;
            rf_done = 1;
          end else waited++;
        end else begin
          check1("rdone_enable", bus.mem_enable_o, 1'b0);
          rd_cnt++;
        end
      end
    end

    check1("access_completed", done, 1'b1);
    check1("hit_mem_idle", bus.mem_enable_o, 1'b0);
    if (h < 0) begin
      check1("wb_seen", wb_done, exp_wb);
      check1("refill_seen", rf_done, 1'b1);
      check32("refill_done_len", 32'(rd_cnt), 32'd1);
      m_line[idx][v]  = get_line(la);
      m_valid[idx][v] = 1'b1;
      m_dirty[idx][v] = 1'b0;
      m_tag[idx][v]   = tg;
      h = v;
    end
    if (!wr) begin
      check32("load_data", bus.p1_data_o, m_line[idx][h][wsel*32 +: 32]);
    end else begin
      m_line[idx][h][wsel*32 +: 32] = wdata;
      m_dirty[idx][h] = 1'b1;
    end
    m_lru[idx] = (h == 0);
  endtask

  initial begin
    logic [MEM_W-1:0] l;
    rst = 1'b1;
    bus.p1_addr_i = '0; bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b0; bus.p1_MemWrite_i = 1'b0;
    bus.mem_data_i = '0; bus.mem_ack_i = 1'b0;
    model_reset();
    l = get_line(32'h40);
    l[63:32] = 32'h11110001;
    mem[32'h40] = l;

    // Reset state, with and without a pending request
    repeat (2) @(negedge clk);
    bus.p1_addr_i = 32'h44; bus.p1_MemRead_i = 1'b1;
    #1;
    check1("rst_stall_req", bus.p1_stall_o, 1'b1);
    check1("rst_enable", bus.mem_enable_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.p1_MemRead_i = 1'b0;
    #1;
    check1("rst_stall_idle", bus.p1_stall_o, 1'b0);
    check1("rst_write", bus.mem_write_o, 1'b0);
    check32("rst_addr", bus.mem_addr_o, 32'h0);
    check32("rst_data_o", bus.p1_data_o, 32'h0);

    // Cold miss, store hit, second way, clean eviction, dirty eviction
    cpu_access(0, 0, 32'h44, 32'h0, 2, 0);
    check32("first_refill_word", bus.p1_data_o, 32'h11110001);
    cpu_access(1, 0, 32'h44, 32'hCAFEF00D, 0, 0);
    cpu_access(0, 0, 32'h44, 32'h0, 0, 0);
    check32("store_readback", bus.p1_data_o, 32'hCAFEF00D);
    cpu_access(0, 0, 32'h244, 32'h0, 1, 0);
    cpu_access(0, 0, 32'h44, 32'h0, 0, 0);
    check32("way0_kept", bus.p1_data_o, 32'hCAFEF00D);
    cpu_access(0, 0, 32'h44, 32'h0, 0, 0);
    cpu_access(0, 0, 32'h444, 32'h0, 0, 0);
    cpu_access(0, 0, 32'h244, 32'h0, 10, 0);

    // Reset in the middle of a refill, then the old line misses again
    cpu_access(0, 0, 32'h844, 32'h0, 1, 1);
    cpu_access(0, 0, 32'h44, 32'h0, 0, 0);
    check32("after_abort_word", bus.p1_data_o, 32'hCAFEF00D);

    // Random traffic over a few sets and tags to force conflicts
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2));
      cpu_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 int'($urandom_range(0, 3)), 0);
    end

    @(negedge clk);
    bus.p1_MemRead_i = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
